// File: rtl/mayo_bram_responder_if.sv
// mayo_bram_responder_if
//  Groups the responder's bus signals: the core BRAMA_* port, the host command
//  port, the LOAD input stream (s_*), the DUMP output stream (m_*) and status.
//  slave  : the responder side (drives BRAMA_dout, s_ready, m_*, busy, done, err)
//  master : the core/host side (drives everything else)
interface mayo_bram_responder_if;
  logic        BRAMA_en;
  logic [3:0]  BRAMA_we;
  logic [31:0] BRAMA_addr;
  logic [31:0] BRAMA_din;
  logic [31:0] BRAMA_dout;
  logic        cmd_start;
  logic        cmd_mode;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_len;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  BRAMA_en, BRAMA_we, BRAMA_addr, BRAMA_din,
    input  cmd_start, cmd_mode, cmd_adr, cmd_len,
    input  s_data, s_valid, m_ready,
    output BRAMA_dout, s_ready, m_data, m_valid, busy, done, err
  );

  modport master (
    output BRAMA_en, BRAMA_we, BRAMA_addr, BRAMA_din,
    output cmd_start, cmd_mode, cmd_adr, cmd_len,
    output s_data, s_valid, m_ready,
    input  BRAMA_dout, s_ready, m_data, m_valid, busy, done, err
  );
endinterface

// File: rtl/mayo_bram_responder.sv
// mayo_bram_responder
//  Word-organised RAM answering the SHAKE core's BRAMA_* port (byte-enabled
//  writes, write-first 1-cycle reads) plus a host command engine that streams
//  words in (LOAD, s_*) or out (DUMP, m_* through a 2-entry FIFO). The core
//  port always wins the single RAM access slot; host accesses wait for it.
// Ports
//  clk, rst : clock, synchronous active-high reset
//  bus      : mayo_bram_responder_if.slave (BRAMA_*, cmd_*, s_*, m_*, busy, done, err)
// Parameters
//  DEPTH (words, power of two), ADDR_W = log2(DEPTH)
// Configuration
//  MAYO_BRAM_OOR_ERR_EN : when defined, accesses with word index >= DEPTH are
//  dropped (reads return 0) and set the sticky err flag; otherwise addresses
//  wrap modulo DEPTH and err is 0.
module mayo_bram_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  mayo_bram_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       rem_q, rem_d;          // words still to write / to read
  logic [31:0]       pop_rem_q, pop_rem_d;  // words still to hand out on m_*
  logic              hoor_q, hoor_d;        // host command started out of range

  logic [31:0]       mem [DEPTH];
  logic [31:0]       dout_q;
  logic [1:0][31:0]  fifo_q;
  logic [1:0]        cnt_q;
  logic              rd_ptr_q, wr_ptr_q;

  logic [ADDR_W-1:0] core_idx, acc_idx;
  logic [31:0]       rd_word, merged;
  logic              core_oor, cmd_oor;
  logic              host_wr, host_rd, pop;

  assign core_idx = bus.BRAMA_addr[ADDR_W+1:2];

`ifdef MAYO_BRAM_OOR_ERR_EN
  logic err_q;
  assign core_oor = |bus.BRAMA_addr[31:ADDR_W+2];
  assign cmd_oor  = |bus.cmd_adr[31:ADDR_W+2];
  assign bus.err  = err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (bus.BRAMA_en & core_oor) | ((host_wr | host_rd) & hoor_q);
  end
  logic unused_bits;
  assign unused_bits = ^{bus.BRAMA_addr[1:0], bus.cmd_adr[1:0]};
`else
  assign core_oor = 1'b0;
  assign cmd_oor  = 1'b0;
  assign bus.err  = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.BRAMA_addr[1:0], bus.BRAMA_addr[31:ADDR_W+2],
                         bus.cmd_adr[1:0], bus.cmd_adr[31:ADDR_W+2]};
`endif

  // Host gets the RAM slot only in cycles the core leaves idle.
  assign bus.s_ready = (state_q == S_LOAD) && !bus.BRAMA_en;
  assign host_wr     = bus.s_valid && bus.s_ready;
  // Issuing only while the FIFO has room keeps every read landable; a pop in
  // the same cycle still lets a full-rate stream run at 1 word/cycle.
  assign host_rd     = (state_q == S_DUMP) && !bus.BRAMA_en && (rem_q != 32'd0) && (cnt_q != 2'd2);
  assign pop         = bus.m_valid && bus.m_ready;

  assign acc_idx = bus.BRAMA_en ? core_idx : ptr_q;
  assign rd_word = mem[acc_idx];

  // Write-first merge: the core sees the word as it will be after this write.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (bus.BRAMA_we[i]) merged[i*8 +: 8] = bus.BRAMA_din[i*8 +: 8];
  end

  // RAM array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.BRAMA_en) begin
      if (|bus.BRAMA_we && !core_oor) mem[core_idx] <= merged;
    end else if (host_wr && !hoor_q) begin
      mem[ptr_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      fifo_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (bus.BRAMA_en) dout_q <= core_oor ? 32'd0 : merged;
      if (host_rd) begin
        fifo_q[wr_ptr_q] <= hoor_q ? 32'd0 : rd_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, host_rd} - {1'b0, pop};
    end
  end

  assign bus.BRAMA_dout = dout_q;
  assign bus.m_valid    = (cnt_q != 2'd0);
  assign bus.m_data     = fifo_q[rd_ptr_q];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      pop_rem_q <= '0;
      hoor_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      pop_rem_q <= pop_rem_d;
      hoor_q    <= hoor_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    pop_rem_d = pop_rem_q;
    hoor_d    = hoor_q;
    unique case (state_q)
      S_IDLE: if (bus.cmd_start) begin
        ptr_d     = bus.cmd_adr[ADDR_W+1:2];
        hoor_d    = cmd_oor;
        rem_d     = bus.cmd_len;
        pop_rem_d = bus.cmd_len;
        if (bus.cmd_len == 32'd0) state_d = S_FIN;
        else                      state_d = bus.cmd_mode ? S_DUMP : S_LOAD;
      end
      S_LOAD: if (host_wr) begin
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = rem_q - 32'd1;
        if (rem_q == 32'd1) state_d = S_FIN;
      end
      S_DUMP: begin
        if (host_rd) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - 32'd1;
        end
        if (pop) begin
          pop_rem_d = pop_rem_q - 32'd1;
          if (pop_rem_q == 32'd1) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mayo_bram_responder.sv
module tb_mayo_bram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mayo_bram_responder_if bus();
  mayo_bram_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] w [8] = '{32'hD808EE98, 32'h38520EBA, 32'hA84F7D23, 32'h0BADF00D,
                         32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0, 32'h5A5AA5A5};
  logic [31:0] l4 [4] = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic core_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.BRAMA_en = 1'b1; bus.BRAMA_we = 4'h0; bus.BRAMA_addr = a;
    tick();
    bus.BRAMA_en = 1'b0;
    chk(tag, bus.BRAMA_dout, exp);
  endtask

  task automatic core_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.BRAMA_en = 1'b1; bus.BRAMA_we = we; bus.BRAMA_addr = a; bus.BRAMA_din = d;
    tick();
    bus.BRAMA_en = 1'b0; bus.BRAMA_we = 4'h0;
  endtask

  task automatic cmd(input logic mode, input logic [31:0] adr, input logic [31:0] len);
    bus.cmd_mode = mode; bus.cmd_adr = adr; bus.cmd_len = len; bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  initial begin
    int k, dones, i, pend;
    logic fire;
    logic [31:0] pexp;
    logic [31:0] rd_a [3] = '{32'h0, 32'h4, 32'h20};
    logic [31:0] rd_e [3] = '{32'hD808EE98, 32'h38520EBA, 32'hFF22CCDD};

    bus.BRAMA_en = 0; bus.BRAMA_we = 0; bus.BRAMA_addr = 0; bus.BRAMA_din = 0;
    bus.cmd_start = 0; bus.cmd_mode = 0; bus.cmd_adr = 0; bus.cmd_len = 0;
    bus.s_data = 0; bus.s_valid = 0; bus.m_ready = 0;

    // Reset values
    tick(); tick();
    chk("rst_dout",    bus.BRAMA_dout, 0);
    chk("rst_sready",  {31'd0, bus.s_ready}, 0);
    chk("rst_mvalid",  {31'd0, bus.m_valid}, 0);
    chk("rst_mdata",   bus.m_data, 0);
    chk("rst_busy",    {31'd0, bus.busy}, 0);
    chk("rst_done",    {31'd0, bus.done}, 0);
    chk("rst_err",     {31'd0, bus.err}, 0);
    rst = 1'b0;
    tick();

    // 1: LOAD 8 words at 0, one per cycle, done on the 9th cycle
    bus.s_valid = 1'b1; bus.s_data = w[0];
    cmd(1'b0, 32'h0, 32'd8);
    chk("t1_busy", {31'd0, bus.busy}, 1);
    chk("t1_sready", {31'd0, bus.s_ready}, 1);
    for (int j = 0; j < 8; j++) begin
      bus.s_data = w[j];
      tick();
      if (j < 7) chk("t1_done_early", {31'd0, bus.done}, 0);
    end
    chk("t1_done", {31'd0, bus.done}, 1);
    bus.s_valid = 1'b0;
    tick();
    chk("t1_done_clr", {31'd0, bus.done}, 0);
    chk("t1_idle", {31'd0, bus.busy}, 0);
    core_rd(32'h0, w[0], "t1_rd0");
    core_rd(32'h4, w[1], "t1_rd4");
    core_rd(32'h1C, w[7], "t1_rd1c");

    // 2: byte-enabled write, write-first read data, hold while idle
    core_wr(32'h20, 4'hF, 32'h11223344);
    core_wr(32'h20, 4'b0011, 32'hAABBCCDD);
    chk("t2_wfirst", bus.BRAMA_dout, 32'h1122CCDD);
    tick();
    chk("t2_hold", bus.BRAMA_dout, 32'h1122CCDD);
    core_rd(32'h20, 32'h1122CCDD, "t2_rd");
    core_wr(32'h20, 4'b1000, 32'hFF000000);
    chk("t2_lane3", bus.BRAMA_dout, 32'hFF22CCDD);

    // 3a: DUMP 3 words at full rate
    bus.m_ready = 1'b1;
    cmd(1'b1, 32'h0, 32'd3);
    tick();
    chk("t3_d0", bus.m_data, w[0]);
    chk("t3_v0", {31'd0, bus.m_valid}, 1);
    tick();
    chk("t3_d1", bus.m_data, w[1]);
    tick();
    chk("t3_d2", bus.m_data, w[2]);
    tick();
    chk("t3_done", {31'd0, bus.done}, 1);
    chk("t3_empty", {31'd0, bus.m_valid}, 0);
    tick();
    chk("t3_idle", {31'd0, bus.busy}, 0);

    // 3b: DUMP with m_ready toggling; order kept, values held, one done
    bus.m_ready = 1'b0;
    cmd(1'b1, 32'h0, 32'd3);
    k = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) dones++;
      if (bus.m_valid) begin
        if (k < 3) chk("t3s_data", bus.m_data, w[k]);
        else       chk("t3s_extra", {31'd0, bus.m_valid}, 0);
      end
      bus.m_ready = c[0];
      if (bus.m_valid && bus.m_ready) k++;
      tick();
    end
    bus.m_ready = 1'b0;
    chk("t3s_count", k, 3);
    chk("t3s_dones", dones, 1);
    chk("t3s_idle", {31'd0, bus.busy}, 0);

    // 4: LOAD 4 words at 0x40, core reads for 3 cycles stall the host
    cmd(1'b0, 32'h40, 32'd4);
    i = 0; pend = 0; pexp = 0;
    for (int c = 0; c < 20 && i < 4; c++) begin
      if (pend != 0) begin chk("t4_core_rd", bus.BRAMA_dout, pexp); pend = 0; end
      if (c >= 1 && c <= 3) begin
        bus.BRAMA_en = 1'b1; bus.BRAMA_we = 4'h0; bus.BRAMA_addr = rd_a[c-1];
        pexp = rd_e[c-1]; pend = 1;
      end else bus.BRAMA_en = 1'b0;
      bus.s_valid = 1'b1; bus.s_data = l4[i];
      #1;
      if (bus.BRAMA_en) chk("t4_sready_stall", {31'd0, bus.s_ready}, 0);
      else              chk("t4_sready", {31'd0, bus.s_ready}, 1);
      fire = bus.s_ready;
      tick();
      if (fire) i++;
    end
    bus.BRAMA_en = 1'b0; bus.s_valid = 1'b0;
    chk("t4_count", i, 4);
    chk("t4_done", {31'd0, bus.done}, 1);
    tick();
    for (int j = 0; j < 4; j++) core_rd(32'h40 + 32'(4*j), l4[j], "t4_rd");

    // 5: LOAD wraps from index 1023 to 0
    bus.s_valid = 1'b1; bus.s_data = 32'hC0FFEE01;
    cmd(1'b0, 32'hFFC, 32'd2);
    tick();
    bus.s_data = 32'hC0FFEE02;
    tick();
    chk("t5_done", {31'd0, bus.done}, 1);
    bus.s_valid = 1'b0;
    tick();
    core_rd(32'hFFC, 32'hC0FFEE01, "t5_rd1023");
    core_rd(32'h0,   32'hC0FFEE02, "t5_rd0");
`ifdef MAYO_BRAM_OOR_ERR_EN
    core_rd(32'h1000, 32'h0, "t5_oor_rd");
    chk("t5_err", {31'd0, bus.err}, 1);
    tick();
    chk("t5_err_sticky", {31'd0, bus.err}, 1);
`else
    core_rd(32'h1000, 32'hC0FFEE02, "t5_wrap_rd");
    chk("t5_err", {31'd0, bus.err}, 0);
`endif

    // 6: reset mid-DUMP, then a zero-length command
    bus.m_ready = 1'b0;
    cmd(1'b1, 32'h40, 32'd4);
    tick();
    tick();
    chk("t6_mvalid", {31'd0, bus.m_valid}, 1);
    chk("t6_mdata", bus.m_data, l4[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_mvalid", {31'd0, bus.m_valid}, 0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 0);
    chk("t6_rst_err", {31'd0, bus.err}, 0);
    core_rd(32'h40, l4[0], "t6_ram_kept");
    cmd(1'b0, 32'h80, 32'd0);
    chk("t6_len0_done", {31'd0, bus.done}, 1);
    chk("t6_len0_sready", {31'd0, bus.s_ready}, 0);
    chk("t6_len0_mvalid", {31'd0, bus.m_valid}, 0);
    tick();
    chk("t6_len0_done_clr", {31'd0, bus.done}, 0);
    chk("t6_len0_idle", {31'd0, bus.busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
